// File: rtl/mix_columns_seq.sv
// AES MixColumns / InvMixColumns over a 128-bit state, one column per cycle on a single shared column datapath.
// Latency: accept on edge E0, out_valid high after edge E4; DONE->IDLE takes one more edge, so at best one state every 6 cycles.
// Backpressure: in_ready only in IDLE; state_out is held in DONE until out_ready, with no overlap between states.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; inv selects 0=MixColumns, 1=InvMixColumns
//   state_in[127:0]      column c = [127-32c -: 32], byte r of column = [31-8r -: 8]
//   out_valid/out_ready  output handshake; state_out uses the same packing
//   busy                 high while a state is in flight (CALC or DONE)
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         inv,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [1:0]    r_col_cnt;
    logic          r_mode;
    logic [127:0]  r_work;

    logic [31:0]   w_col;
    logic [31:0]   w_col_out;
    logic [7:0]    w_a  [4];
    logic [7:0]    w_m2 [4];
    logic [7:0]    w_m3 [4];
    logic [7:0]    w_m9 [4];
    logic [7:0]    w_mb [4];
    logic [7:0]    w_md [4];
    logic [7:0]    w_me [4];

    // Multiply-by-constant LUTs in GF(2^8), reduction polynomial 0x11B.
    function automatic logic [7:0] gf_x2(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction
    function automatic logic [7:0] gf_x3(input logic [7:0] v);
        return gf_x2(v) ^ v;
    endfunction
    function automatic logic [7:0] gf_x9(input logic [7:0] v);
        return gf_x2(gf_x2(gf_x2(v))) ^ v;
    endfunction
    function automatic logic [7:0] gf_xb(input logic [7:0] v);
        return gf_x2(gf_x2(gf_x2(v))) ^ gf_x2(v) ^ v;
    endfunction
    function automatic logic [7:0] gf_xd(input logic [7:0] v);
        return gf_x2(gf_x2(gf_x2(v))) ^ gf_x2(gf_x2(v)) ^ v;
    endfunction
    function automatic logic [7:0] gf_xe(input logic [7:0] v);
        return gf_x2(gf_x2(gf_x2(v))) ^ gf_x2(gf_x2(v)) ^ gf_x2(v);
    endfunction

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid)           w_next = S_CALC;
            S_CALC:  if (r_col_cnt == 2'd3)  w_next = S_DONE;
            S_DONE:  if (out_ready)          w_next = S_IDLE;
            default:                         w_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state == S_CALC) || (r_state == S_DONE);
        state_out = r_work;
    end

    // ---------------- Shared column datapath ----------------
    always_comb begin
        case (r_col_cnt)
            2'd0:    w_col = r_work[127:96];
            2'd1:    w_col = r_work[95:64];
            2'd2:    w_col = r_work[63:32];
            default: w_col = r_work[31:0];
        endcase
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            w_a[r]  = w_col[31-8*r -: 8];
            w_m2[r] = gf_x2(w_a[r]);
            w_m3[r] = gf_x3(w_a[r]);
            w_m9[r] = gf_x9(w_a[r]);
            w_mb[r] = gf_xb(w_a[r]);
            w_md[r] = gf_xd(w_a[r]);
            w_me[r] = gf_xe(w_a[r]);
        end
        if (r_mode) begin
            // Inverse rows: (0e 0b 0d 09) rotated right by the output row index.
            w_col_out = {w_me[0] ^ w_mb[1] ^ w_md[2] ^ w_m9[3],
                         w_m9[0] ^ w_me[1] ^ w_mb[2] ^ w_md[3],
                         w_md[0] ^ w_m9[1] ^ w_me[2] ^ w_mb[3],
                         w_mb[0] ^ w_md[1] ^ w_m9[2] ^ w_me[3]};
        end else begin
            w_col_out = {w_m2[0] ^ w_m3[1] ^ w_a[2]  ^ w_a[3],
                         w_a[0]  ^ w_m2[1] ^ w_m3[2] ^ w_a[3],
                         w_a[0]  ^ w_a[1]  ^ w_m2[2] ^ w_m3[3],
                         w_m3[0] ^ w_a[1]  ^ w_a[2]  ^ w_m2[3]};
        end
    end

    // ---------------- Working register, mode, column counter ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_work    <= '0;
            r_mode    <= 1'b0;
            r_col_cnt <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_work    <= state_in;
                        r_mode    <= inv;
                        r_col_cnt <= 2'd0;
                    end
                end
                S_CALC: begin
                    case (r_col_cnt)
                        2'd0:    r_work[127:96] <= w_col_out;
                        2'd1:    r_work[95:64]  <= w_col_out;
                        2'd2:    r_work[63:32]  <= w_col_out;
                        default: r_work[31:0]   <= w_col_out;
                    endcase
                    // Wraps 3->0 exactly on the CALC->DONE edge.
                    r_col_cnt <= r_col_cnt + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
`timescale 1ns/1ps
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic         inv;
    logic [127:0] state_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] state_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    mix_columns_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inv       (inv),
        .state_in  (state_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .state_out (state_out),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Reference: shift-and-add GF(2^8) multiply and a matrix-times-column product.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_mix(input logic [127:0] s, input logic m);
        logic [7:0]   row [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        if (m) begin
            row[0] = 8'h0e; row[1] = 8'h0b; row[2] = 8'h0d; row[3] = 8'h09;
        end else begin
            row[0] = 8'h02; row[1] = 8'h03; row[2] = 8'h01; row[3] = 8'h01;
        end
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(row[(j - i + 4) % 4], s[127-32*c-8*j -: 8]);
                r[127-32*c-8*i -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with optional input scrambling during CALC and random out_ready.
    task automatic run_one(input logic [127:0] s, input logic m, input bit rand_ready,
                           input bit scramble, output logic [127:0] res);
        int           edges;
        logic [127:0] held;
        logic [127:0] expv;
        expv = ref_mix(s, m);
        chk("in_ready_idle", in_ready, 1);
        in_valid  = 1'b1;
        state_in  = s;
        inv       = m;
        out_ready = rand_ready ? 1'($urandom % 2) : 1'b1;
        tick;
        edges = 1;
        chk("busy_after_accept", busy, 1);
        while (!out_valid && edges < 12) begin
            if (scramble) begin
                in_valid = 1'($urandom % 2);
                state_in = {$urandom, $urandom, $urandom, $urandom};
                inv      = ~inv;
            end else begin
                in_valid = 1'b0;
            end
            if (rand_ready) out_ready = 1'($urandom % 2);
            tick;
            edges++;
        end
        in_valid = 1'b0;
        chk("latency_edges", edges, 5);
        chk("out_valid_done", out_valid, 1);
        chk("result", state_out, expv);
        chk("in_ready_done", in_ready, 0);
        held = state_out;
        res  = state_out;
        for (int k = 0; k < 30; k++) begin
            out_ready = (rand_ready && k < 20) ? 1'($urandom % 2) : 1'b1;
            tick;
            if (out_ready) break;
            chk("hold_valid", out_valid, 1);
            chk("hold_data", state_out, held);
        end
        chk("drop_valid", out_valid, 0);
        chk("back_idle", in_ready, 1);
    endtask

    initial begin
        logic [127:0] r_fwd;
        logic [127:0] r_tmp;
        logic [127:0] s;
        logic         m;
        bit           spurious;

        rst = 1'b1; in_valid = 1'b0; inv = 1'b0; state_in = '0; out_ready = 1'b0;
        tick;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_state_out", state_out, 0);

        // No accept on a reset edge.
        in_valid = 1'b1; state_in = {4{32'h12345678}};
        tick;
        chk("no_accept_on_rst", busy, 0);
        chk("no_capture_on_rst", state_out, 0);
        rst = 1'b0; in_valid = 1'b0;
        tick;
        chk("idle_hold", state_out, 0);

        // Forward known-answer vector.
        run_one(128'hdb135345_f20a225c_01010101_c6c6c6c6, 1'b0, 1'b0, 1'b0, r_fwd);
        chk("fwd_kat", r_fwd, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6);

        // Inverse round trip.
        run_one(r_fwd, 1'b1, 1'b0, 1'b0, r_tmp);
        chk("inv_kat", r_tmp, 128'hdb135345_f20a225c_01010101_c6c6c6c6);

        // Backpressure: 10 cycles of out_ready=0 in DONE.
        in_valid = 1'b1; inv = 1'b0; state_in = {4{32'hd4d4d4d5}}; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) tick;
        chk("bp_valid", out_valid, 1);
        chk("bp_data", state_out, {4{32'hd5d5d7d6}});
        for (int k = 0; k < 10; k++) begin
            tick;
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", state_out, {4{32'hd5d5d7d6}});
            chk("bp_hold_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        tick;
        chk("bp_transfer_drop", out_valid, 0);
        chk("bp_idle", in_ready, 1);
        tick;
        chk("bp_single_transfer", out_valid, 0);

        // Inputs changed during CALC must not disturb the captured state.
        run_one(128'h0123456789abcdef_fedcba9876543210, 1'b0, 1'b0, 1'b1, r_tmp);
        run_one(128'h00112233_44556677_8899aabb_ccddeeff, 1'b1, 1'b0, 1'b1, r_tmp);

        // Reset at col_cnt=2 discards the state in flight.
        in_valid = 1'b1; inv = 1'b0; state_in = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("midcalc_rst_valid", out_valid, 0);
        chk("midcalc_rst_in_ready", in_ready, 1);
        chk("midcalc_rst_data", state_out, 0);
        spurious = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick;
            if (out_valid) spurious = 1'b1;
        end
        chk("midcalc_no_spurious", spurious, 0);

        // Reset in DONE with out_ready=0.
        in_valid = 1'b1; state_in = {4{32'hd4d4d4d5}}; out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick;
        chk("done_before_rst", out_valid, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("done_rst_valid", out_valid, 0);
        chk("done_rst_data", state_out, 0);
        chk("done_rst_busy", busy, 0);
        out_ready = 1'b1;
        tick;

        // Random back-to-back traffic.
        for (int n = 0; n < 1000; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            m = 1'($urandom % 2);
            run_one(s, m, 1'b1, 1'($urandom % 2), r_tmp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
